// File: rtl/sim_adc_pkg.sv
// Shared constants and types for the simulated ADC128S022 responder.
// Frame geometry, address bit positions within the frame, status word layout
// and the channel value type all live here.
package sim_adc_pkg;

   localparam int NUM_CH        = 8;
   localparam int CH_BITS       = 3;
   localparam int DATA_WIDTH    = 12;
   localparam int FRAME_BITS    = 16;
   localparam int SYNC_STAGES   = 2;
   localparam int CNT_BITS      = 4;
   localparam int ADDR_MSB_RISE = 3;
   localparam int LEADING_ZEROS = 4;

   localparam int STAT_ERR_BIT  = 15;
   localparam int STAT_CH_LSB   = 12;
   localparam int STAT_CNT_MSB  = 11;

   typedef logic [DATA_WIDTH-1:0] chan_val_t;

   // A conversion result as it goes out on DOUT: leading zeros, then the value
   function automatic logic [FRAME_BITS-1:0] frame_word(input chan_val_t value);
      return {{LEADING_ZEROS{1'b0}}, value};
   endfunction

endpackage

// File: rtl/sim_adc_sync_edge.sv
// Synchronizer for one asynchronous SPI pin followed by a one-flop edge
// detector. RESET_VAL sets the idle level the chain assumes during reset so
// that leaving reset never produces a false edge. STAGES must be at least 2.
module sim_adc_sync_edge #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b1
) (
   input  logic sysclk,
   input  logic sim_reset,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              prev;

   // Shift the pin through the synchronizer and keep the previous synced level
   always_ff @(posedge sysclk or posedge sim_reset) begin
      if (sim_reset) begin
         chain <= {STAGES{RESET_VAL}};
         prev  <= RESET_VAL;
      end else begin
         chain <= {chain[STAGES-2:0], pin};
         prev  <= chain[STAGES-1];
      end
   end

   assign level = chain[STAGES-1];
   assign rise  = level & ~prev;
   assign fall  = ~level & prev;

endmodule

// File: rtl/sim_adc_responder.sv
// SPI responder modelling the ADC128S022 8-channel 12-bit ADC.
// The address received in one frame selects the data returned in the next.
// Optional build macro: SIM_ADC_PROTOCOL_CHECK_EN enables the sticky protocol
// error flag reported in status_out[15]; without it that bit is tied to 0.
module sim_adc_responder
   import sim_adc_pkg::*;
(
   input  logic        sysclk,
   input  logic        sim_reset,
   input  logic        adc_cs_n,
   input  logic        adc_sclk,
   input  logic        adc_saddr,
   output logic        adc_sdat,
   input  logic [15:0] data_in,
   input  logic        value_load,
   input  logic        status_clear,
   output logic [15:0] status_out,
   output logic        frame_done
);

   logic cs_n_s, cs_rise, cs_fall;
   logic sclk_level, sclk_rise, sclk_fall;
   logic saddr_s, saddr_rise, saddr_fall;

   chan_val_t                 chan_val [NUM_CH];
   logic [FRAME_BITS-1:0]     shift_reg;
   logic [FRAME_BITS-1:0]     load_word;
   logic [CH_BITS-1:0]        addr_sr;
   logic [CNT_BITS-1:0]       rise_cnt;
   logic [CNT_BITS-1:0]       fall_cnt;
   logic [CH_BITS-1:0]        next_ch;
   logic [CH_BITS-1:0]        last_ch;
   logic [STAT_CNT_MSB:0]     frame_cnt;
   logic                      err_flag;
   logic                      in_frame;
   logic                      addr_window;
   logic                      frame_end;
   logic                      unused_bits;

   sim_adc_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
      .sysclk(sysclk), .sim_reset(sim_reset), .pin(adc_cs_n),
      .level(cs_n_s), .rise(cs_rise), .fall(cs_fall)
   );

   sim_adc_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
      .sysclk(sysclk), .sim_reset(sim_reset), .pin(adc_sclk),
      .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
   );

   sim_adc_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_saddr (
      .sysclk(sysclk), .sim_reset(sim_reset), .pin(adc_saddr),
      .level(saddr_s), .rise(saddr_rise), .fall(saddr_fall)
   );

   assign unused_bits = ^{saddr_rise, saddr_fall, sclk_level, data_in[15]};

   assign in_frame    = ~cs_n_s & ~cs_fall;
   assign load_word   = frame_word(chan_val[next_ch]);
   assign addr_window = (rise_cnt >= CNT_BITS'(ADDR_MSB_RISE - 1)) &&
                        (rise_cnt <= CNT_BITS'(ADDR_MSB_RISE + 1));
   assign frame_end   = in_frame && sclk_rise && (rise_cnt == CNT_BITS'(FRAME_BITS - 1));
   assign adc_sdat    = shift_reg[FRAME_BITS-1] & ~cs_n_s;

   // Channel value RAM written by the simulator MCU
   always_ff @(posedge sysclk or posedge sim_reset) begin
      if (sim_reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            chan_val[i] <= '0;
         end
      end else if (value_load) begin
         chan_val[data_in[STAT_CH_LSB +: CH_BITS]] <= data_in[DATA_WIDTH-1:0];
      end
   end

   // SPI shifting: snapshot at cs fall and first SCLK fall, shift DOUT on falls, sample DIN on rises
   always_ff @(posedge sysclk or posedge sim_reset) begin
      if (sim_reset) begin
         shift_reg <= '0;
         addr_sr   <= '0;
         rise_cnt  <= '0;
         fall_cnt  <= '0;
      end else if (cs_fall) begin
         shift_reg <= load_word;
         rise_cnt  <= '0;
         fall_cnt  <= '0;
      end else if (cs_rise) begin
         rise_cnt  <= '0;
         fall_cnt  <= '0;
      end else if (in_frame) begin
         if (sclk_fall) begin
            shift_reg <= (fall_cnt == '0) ? load_word : {shift_reg[FRAME_BITS-2:0], 1'b0};
            fall_cnt  <= fall_cnt + 1'b1;
         end
         if (sclk_rise) begin
            if (addr_window) begin
               addr_sr <= {addr_sr[CH_BITS-2:0], saddr_s};
            end
            rise_cnt <= rise_cnt + 1'b1;
         end
      end
   end

   // Frame completion: latch the received address, count the frame, pulse frame_done
   always_ff @(posedge sysclk or posedge sim_reset) begin
      if (sim_reset) begin
         next_ch    <= '0;
         last_ch    <= '0;
         frame_cnt  <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= frame_end;
         if (frame_end) begin
            next_ch <= addr_sr;
            last_ch <= addr_sr;
         end
         if (status_clear) begin
            frame_cnt <= '0;
         end else if (frame_end) begin
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end

`ifdef SIM_ADC_PROTOCOL_CHECK_EN
   logic [CNT_BITS-1:0] cnt_diff;
   logic                proto_err;

   assign cnt_diff  = fall_cnt - rise_cnt;
   assign proto_err = (cs_rise && (rise_cnt != '0)) ||
                      (in_frame && (cnt_diff > CNT_BITS'(1)) &&
                       (cnt_diff < CNT_BITS'(FRAME_BITS - 1)));

   // Sticky protocol error: aborted frames or SCLK edge counts drifting apart
   always_ff @(posedge sysclk or posedge sim_reset) begin
      if (sim_reset) begin
         err_flag <= 1'b0;
      end else if (status_clear) begin
         err_flag <= 1'b0;
      end else if (proto_err) begin
         err_flag <= 1'b1;
      end
   end
`else
   assign err_flag = 1'b0;
`endif

   // Assemble the status word from its fields
   always_comb begin
      status_out                          = '0;
      status_out[STAT_ERR_BIT]            = err_flag;
      status_out[STAT_CH_LSB +: CH_BITS]  = last_ch;
      status_out[STAT_CNT_MSB:0]          = frame_cnt;
   end

endmodule

// File: tb/tb_sim_adc_responder.sv
// Self-checking bench for sim_adc_responder. Acts as the SPI master and as the
// simulator MCU, and predicts DOUT words and status from a small channel model.
module tb_sim_adc_responder;

   localparam int HALF = 6;

`ifdef SIM_ADC_PROTOCOL_CHECK_EN
   localparam logic CHECK_EN = 1'b1;
`else
   localparam logic CHECK_EN = 1'b0;
`endif

   logic        sysclk = 1'b0;
   logic        sim_reset;
   logic        adc_cs_n;
   logic        adc_sclk;
   logic        adc_saddr;
   logic        adc_sdat;
   logic [15:0] data_in;
   logic        value_load;
   logic        status_clear;
   logic [15:0] status_out;
   logic        frame_done;

   int check_cnt = 0;
   int pass_cnt  = 0;
   int done_cnt  = 0;

   logic [11:0] m_val [8];
   logic [2:0]  m_next;
   logic [2:0]  m_last;
   logic [11:0] m_cnt;
   logic        m_err;

   sim_adc_responder dut (
      .sysclk(sysclk), .sim_reset(sim_reset),
      .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_saddr(adc_saddr),
      .adc_sdat(adc_sdat), .data_in(data_in), .value_load(value_load),
      .status_clear(status_clear), .status_out(status_out), .frame_done(frame_done)
   );

   always #10 sysclk = ~sysclk;

   always @(posedge sysclk) begin
      if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
   end

   initial begin
      #5000000;
      $display("[TB] FAIL timeout: observed no end of test, expected finish");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_cnt++;
      if (observed === expected) pass_cnt++;
      else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge sysclk);
   endtask

   task automatic modelReset();
      for (int i = 0; i < 8; i++) m_val[i] = '0;
      m_next = '0;
      m_last = '0;
      m_cnt  = '0;
      m_err  = 1'b0;
   endtask

   function automatic logic [15:0] expStatus();
      return {m_err, m_last, m_cnt};
   endfunction

   task automatic loadValue(input logic [2:0] ch, input logic [11:0] val, input logic clr);
      @(negedge sysclk);
      data_in      = {1'($urandom), ch, val};
      value_load   = 1'b1;
      status_clear = clr;
      @(negedge sysclk);
      value_load   = 1'b0;
      status_clear = 1'b0;
      m_val[ch]    = val;
      if (clr) begin
         m_cnt = '0;
         m_err = 1'b0;
      end
   endtask

   task automatic clearStatus();
      @(negedge sysclk);
      status_clear = 1'b1;
      @(negedge sysclk);
      status_clear = 1'b0;
      m_cnt = '0;
      m_err = 1'b0;
   endtask

   // Drives nclk SCLK periods; the address rides on rises 3..5, other DIN bits are random
   task automatic applyStimulus(input logic [2:0] addr, input int nclk, input logic lower_cs,
                                input logic raise_cs, input logic mid_load,
                                input logic [15:0] mid_word, output logic [15:0] rx);
      rx = '0;
      if (lower_cs) begin
         adc_cs_n = 1'b0;
         waitCycles(HALF);
      end
      for (int b = 0; b < nclk; b++) begin
         adc_sclk  = 1'b0;
         adc_saddr = (b >= 2 && b <= 4) ? addr[4-b] : 1'($urandom);
         waitCycles(HALF);
         rx = {rx[14:0], adc_sdat};
         adc_sclk = 1'b1;
         if (mid_load && b == 7) begin
            @(negedge sysclk);
            data_in    = mid_word;
            value_load = 1'b1;
            @(negedge sysclk);
            value_load = 1'b0;
            m_val[mid_word[14:12]] = mid_word[11:0];
         end
         waitCycles(HALF);
      end
      if (raise_cs) begin
         adc_cs_n  = 1'b1;
         adc_saddr = 1'b0;
         waitCycles(HALF);
      end
   endtask

   task automatic runFullFrame(input string tag, input logic [2:0] addr, input logic lower_cs,
                               input logic raise_cs, input logic mid_load, input logic [15:0] mid_word);
      logic [15:0] rx;
      logic [15:0] exp_word;
      int          d0;
      exp_word = {4'h0, m_val[m_next]};
      d0       = done_cnt;
      applyStimulus(addr, 16, lower_cs, raise_cs, mid_load, mid_word, rx);
      m_next = addr;
      m_last = addr;
      m_cnt  = m_cnt + 12'd1;
      checkOutput({tag, " data"}, 32'(rx), 32'(exp_word));
      checkOutput({tag, " done"}, 32'(done_cnt - d0), 32'd1);
      checkOutput({tag, " status"}, 32'(status_out), 32'(expStatus()));
   endtask

   initial begin
      logic [15:0] rx;
      logic        cs_low;
      int          d0;

      sim_reset    = 1'b1;
      adc_cs_n     = 1'b1;
      adc_sclk     = 1'b1;
      adc_saddr    = 1'b0;
      data_in      = '0;
      value_load   = 1'b0;
      status_clear = 1'b0;
      modelReset();
      waitCycles(5);
      checkOutput("reset status", 32'(status_out), 32'h0);
      checkOutput("reset sdat", 32'(adc_sdat), 32'h0);
      checkOutput("reset done", 32'(frame_done), 32'h0);
      sim_reset = 1'b0;
      waitCycles(4);

      // Basic frames
      loadValue(3'd0, 12'hABC, 1'b0);
      runFullFrame("t1", 3'd5, 1'b1, 1'b1, 1'b0, 16'h0);
      checkOutput("t1 status const", 32'(status_out), 32'h5001);
      loadValue(3'd5, 12'h123, 1'b0);
      runFullFrame("t2", 3'd2, 1'b1, 1'b1, 1'b0, 16'h0);
      checkOutput("t2 status const", 32'(status_out), 32'h2002);

      // Back-to-back frames with cs held low
      loadValue(3'd0, 12'h0AA, 1'b0);
      runFullFrame("t3 pre", 3'd0, 1'b1, 1'b1, 1'b0, 16'h0);
      clearStatus();
      loadValue(3'd1, 12'h111, 1'b0);
      loadValue(3'd2, 12'h222, 1'b0);
      runFullFrame("t3 f1", 3'd1, 1'b1, 1'b0, 1'b0, 16'h0);
      runFullFrame("t3 f2", 3'd2, 1'b0, 1'b0, 1'b0, 16'h0);
      runFullFrame("t3 f3", 3'd3, 1'b0, 1'b1, 1'b0, 16'h0);
      checkOutput("t3 status const", 32'(status_out), 32'h3003);

      // Aborted frame after 9 SCLKs
      loadValue(3'd3, 12'h333, 1'b0);
      d0 = done_cnt;
      applyStimulus(3'd6, 9, 1'b1, 1'b1, 1'b0, 16'h0, rx);
      m_err = CHECK_EN;
      checkOutput("abort done", 32'(done_cnt - d0), 32'd0);
      checkOutput("abort status", 32'(status_out), 32'(expStatus()));
      checkOutput("abort err bit", 32'(status_out[15]), 32'(CHECK_EN));
      runFullFrame("after abort", 3'd4, 1'b1, 1'b1, 1'b0, 16'h0);
      clearStatus();
      checkOutput("err cleared", 32'(status_out), 32'(expStatus()));

      // Value load during a frame
      loadValue(3'd4, 12'h444, 1'b0);
      runFullFrame("midload", 3'd4, 1'b1, 1'b1, 1'b1, {1'b0, 3'd4, 12'hFFF});
      runFullFrame("midload next", 3'd1, 1'b1, 1'b1, 1'b0, 16'h0);

      // Load and clear in the same cycle
      loadValue(3'd1, 12'h5A5, 1'b1);
      checkOutput("load+clear status", 32'(status_out), 32'(expStatus()));
      runFullFrame("load+clear frame", 3'd7, 1'b1, 1'b1, 1'b0, 16'h0);

      // Randomized frames
      cs_low = 1'b0;
      for (int n = 0; n < 24; n++) begin
         logic raise;
         if ($urandom_range(0, 4) == 0) clearStatus();
         repeat ($urandom_range(0, 2)) loadValue(3'($urandom_range(0, 7)), 12'($urandom), 1'b0);
         raise = ($urandom_range(0, 2) != 0);
         runFullFrame($sformatf("rnd%0d", n), 3'($urandom_range(0, 7)), !cs_low, raise, 1'b0, 16'h0);
         cs_low = !raise;
      end
      if (cs_low) begin
         adc_cs_n = 1'b1;
         waitCycles(HALF);
      end

      // Reset in the middle of a frame
      loadValue(m_next, 12'hFFF, 1'b0);
      applyStimulus(3'd6, 6, 1'b1, 1'b0, 1'b0, 16'h0, rx);
      checkOutput("prereset sdat", 32'(adc_sdat), 32'h1);
      @(negedge sysclk);
      sim_reset = 1'b1;
      #1;
      checkOutput("midreset sdat", 32'(adc_sdat), 32'h0);
      checkOutput("midreset status", 32'(status_out), 32'h0);
      adc_cs_n = 1'b1;
      adc_sclk = 1'b1;
      waitCycles(3);
      sim_reset = 1'b0;
      modelReset();
      waitCycles(4);
      runFullFrame("postreset", 3'($urandom_range(0, 7)), 1'b1, 1'b1, 1'b0, 16'h0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
